cache_nwsa: RTL and testbench
=============================

Name: cache_nwsa

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache sitting between the CPU byte/word port and main memory. It generalises the existing 2-way cache in ways, sets, line length and data width. It adds true-LRU replacement, dirty-line write-back bursts and a stall-based CPU handshake. Memory transfers are line bursts paced word-by-word by ready_mem.

Parameters:
ADDR_W, 16, address width, CPU and memory
DATA_W, 8, word width
WAYS, 2, associativity; power of 2, 1..8
SETS, 16, sets; power of 2
WORDS, 4, words per line; power of 2, >=2

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
addr_cpu  in  ADDR_W  CPU address, held stable while stall_cpu=1
rd_cpu  in  1  CPU read request
wr_cpu  in  1  CPU write request; wins if rd_cpu also high
data_cpu_in  in  DATA_W  CPU write data
data_cpu_out  out  DATA_W  read data, valid when rd_valid=1
rd_valid  out  1  one-cycle read-complete pulse
stall_cpu  out  1  request in progress; CPU must hold inputs
addr_mem  out  ADDR_W  memory word address
rd_mem  out  1  refill burst active
wr_mem  out  1  write-back burst active
data_mem_in  in  DATA_W  refill data, sampled when ready_mem=1
data_mem_out  out  DATA_W  write-back data
ready_mem  in  1  memory accepts/supplies one word this cycle
hit_count  out  16  hit counter (see Optional Feature)
miss_count  out  16  miss counter (see Optional Feature)

Behaviour:
- Address split, LSB first: offset = log2(WORDS) bits, index = log2(SETS) bits, tag = the remainder.
- Reset (async): all valid, dirty and LRU ages cleared; state IDLE. All outputs 0. Reset during a burst aborts it; no write-back occurs.
- FSM states: IDLE, WRITEBACK, REFILL, RESPOND.
- IDLE, request present:
  - Hit detection is combinational.
  - Read hit: data_cpu_out is registered; rd_valid pulses at the next edge; stall_cpu stays 0. Latency is 1 cycle.
  - Write hit: the word is written and the line marked dirty at the next edge. No stall.
  - Miss: stall_cpu=1 from the next edge. The victim is the lowest-index invalid way; otherwise the LRU way.
  - Dirty victim goes to WRITEBACK; clean victim goes to REFILL.
- WRITEBACK:
  - wr_mem=1; addr_mem = {victim tag, index, cnt}; data_mem_out = victim word[cnt].
  - cnt starts at 0 and increments on each ready_mem=1.
  - After word WORDS-1 is accepted, go to REFILL with cnt=0 and wr_mem dropping.
- REFILL:
  - rd_mem=1; addr_mem = {new tag, index, cnt}.
  - On ready_mem=1, data_mem_in is written to word[cnt] and cnt increments.
  - After the last word: tag written, valid=1, dirty=0, go to RESPOND.
- Memory stall: ready_mem held low indefinitely holds the state, address and data unchanged.
- RESPOND: perform the original access as a hit; a write sets dirty. Then stall_cpu=0 and rd_valid pulses (reads) at the next edge, and the FSM returns to IDLE.
- LRU:
  - Each way holds a log2(WAYS)-bit age per set.
  - On every hit or fill, the accessed way gets age 0; ways whose age was below the accessed way's old age increment.
  - Victim = the way with age WAYS-1.
  - WAYS=1 means direct-mapped, with no age storage.
- rd_cpu and wr_cpu are ignored while stall_cpu=1.
- rd_cpu and wr_cpu both high: treated as a write.
- Neither high: no state change.

Optional Feature:
CACHE_STATS_EN
- Defined: hit_count and miss_count increment once per completed CPU request (a hit in IDLE, or a miss on entry to WRITEBACK/REFILL). Both saturate at 0xFFFF and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
Defaults used throughout; 0xC08B decodes to tag 0x302, index 2, offset 3.
1. Read miss 0xC08B on an empty cache -> stall_cpu=1; rd_mem=1 with addr_mem 0xC088..0xC08B; memory supplies 11,22,33,44 with ready_mem=1 -> data_cpu_out=0x44 with rd_valid; stall_cpu=0; wr_mem never asserted.
2. Read 0xC089 afterwards -> hit; no stall; data_cpu_out=0x22 one cycle later.
3. Write 0xC08A=0x5A (hit, dirty), then read-miss 0x008B (fills way1), then read-miss 0x408B:
   - Way0 is evicted.
   - Write-back on addr_mem 0xC088..0xC08B carries data 11,22,5A,44.
   - Refill then runs on 0x4088..0x408B.
4. ready_mem toggled 1,0,0,1,... during a refill -> addr_mem advances only on ready_mem=1; the final data is correct.
5. reset_n pulled low after the second refill word, then a read of 0xC08B -> full miss refill from 0xC088; no write-back.
6. With CACHE_STATS_EN defined, run scenarios 1-3 -> hit_count=2, miss_count=3. With it undefined, both read 0.

Source files
------------

// File: rtl/cache_nwsa.sv
// cache_nwsa: N-way set-associative, write-back, write-allocate cache between
// a CPU word port and main memory. True-LRU replacement, dirty-line write-back
// bursts, and a stall-based CPU handshake. Memory bursts are paced by ready_mem.
//
// Optional build macro: CACHE_STATS_EN enables saturating hit/miss counters;
// without it hit_count and miss_count are tied to zero.
//
// Ports:
//   clock, reset_n               rising-edge clock, async active-low reset
//   addr_cpu, rd_cpu, wr_cpu     CPU request (write wins when both are high)
//   data_cpu_in / data_cpu_out   CPU write data / registered read data
//   rd_valid                     one-cycle read-complete pulse
//   stall_cpu                    miss in progress, CPU holds its inputs
//   addr_mem, rd_mem, wr_mem     memory word address, refill / write-back burst
//   data_mem_in / data_mem_out   refill data in / write-back data out
//   ready_mem                    memory moves one word this cycle
//   hit_count, miss_count        statistics counters
//
// state     | meaning
// IDLE      | serve hits, detect misses
// WRITEBACK | stream dirty victim line to memory
// REFILL    | fetch the new line from memory
// RESPOND   | complete the stalled access as a hit
module cache_nwsa #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int WORDS  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_cpu,
    input  logic              rd_cpu,
    input  logic              wr_cpu,
    input  logic [DATA_W-1:0] data_cpu_in,
    output logic [DATA_W-1:0] data_cpu_out,
    output logic              rd_valid,
    output logic              stall_cpu,
    output logic [ADDR_W-1:0] addr_mem,
    output logic              rd_mem,
    output logic              wr_mem,
    input  logic [DATA_W-1:0] data_mem_in,
    output logic [DATA_W-1:0] data_mem_out,
    input  logic              ready_mem,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic              valid_q [WAYS][SETS];
    logic              dirty_q [WAYS][SETS];

    logic [OFF_W-1:0]  cnt_q;
    logic [WAY_W-1:0]  victim_q;
    logic              pend_wr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [TAG_W-1:0]  tag_in;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              req, hit, found, last_word, lru_en;
    logic [WAY_W-1:0]  hit_way, victim, lru_vict, lru_way;

    assign tag_in    = addr_cpu[ADDR_W-1 -: TAG_W];
    assign idx       = addr_cpu[OFF_W +: IDX_W];
    assign off       = addr_cpu[OFF_W-1:0];
    assign req       = (state_q == IDLE) && (rd_cpu || wr_cpu);
    assign last_word = (cnt_q == OFF_W'(WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag_in)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Prefer the lowest invalid way; fall back to the LRU way.
    always_comb begin
        victim = lru_vict;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[w][idx]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    assign lru_en  = (req && hit) || ((state_q == REFILL) && ready_mem && last_word);
    assign lru_way = (state_q == IDLE) ? hit_way : victim_q;

    generate
        if (WAYS > 1) begin : g_lru
            logic [WAY_W-1:0] age_q [WAYS][SETS];
            logic [WAY_W-1:0] old_age;

            // A way being filled from invalid is treated as oldest, so every
            // other way ages; this keeps the ages a permutation after reset.
            assign old_age = valid_q[lru_way][idx] ? age_q[lru_way][idx] : WAY_W'(WAYS - 1);

            always_comb begin
                lru_vict = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (age_q[w][idx] == WAY_W'(WAYS - 1)) lru_vict = WAY_W'(w);
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int w = 0; w < WAYS; w++)
                        for (int s = 0; s < SETS; s++) age_q[w][s] <= '0;
                end else if (lru_en) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == lru_way)       age_q[w][idx] <= '0;
                        else if (age_q[w][idx] < old_age) age_q[w][idx] <= age_q[w][idx] + WAY_W'(1);
                    end
                end
            end
        end else begin : g_direct
            assign lru_vict = '0;
        end
    endgenerate

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req && !hit)
                           state_d = (valid_q[victim][idx] && dirty_q[victim][idx]) ? WRITEBACK : REFILL;
            WRITEBACK: if (ready_mem && last_word) state_d = REFILL;
            REFILL:    if (ready_mem && last_word) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        stall_cpu    = (state_q != IDLE);
        wr_mem       = (state_q == WRITEBACK);
        rd_mem       = (state_q == REFILL);
        addr_mem     = '0;
        data_mem_out = '0;
        if (state_q == WRITEBACK) begin
            addr_mem     = {tag_q[victim_q][idx], idx, cnt_q};
            data_mem_out = data_q[victim_q][idx][cnt_q];
        end else if (state_q == REFILL) begin
            addr_mem = {tag_in, idx, cnt_q};
        end
    end

    // Control and line status
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            victim_q     <= '0;
            pend_wr_q    <= 1'b0;
            wdata_q      <= '0;
            data_cpu_out <= '0;
            rd_valid     <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            rd_valid <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    if (hit) begin
                        if (wr_cpu) begin
                            dirty_q[hit_way][idx] <= 1'b1;
                        end else begin
                            data_cpu_out <= data_q[hit_way][idx][off];
                            rd_valid     <= 1'b1;
                        end
                    end else begin
                        victim_q  <= victim;
                        pend_wr_q <= wr_cpu;
                        wdata_q   <= data_cpu_in;
                        cnt_q     <= '0;
                    end
                end
                WRITEBACK: if (ready_mem) cnt_q <= cnt_q + OFF_W'(1);
                REFILL: if (ready_mem) begin
                    cnt_q <= cnt_q + OFF_W'(1);
                    if (last_word) begin
                        valid_q[victim_q][idx] <= 1'b1;
                        dirty_q[victim_q][idx] <= 1'b0;
                    end
                end
                RESPOND: begin
                    if (pend_wr_q) begin
                        dirty_q[victim_q][idx] <= 1'b1;
                    end else begin
                        data_cpu_out <= data_q[victim_q][idx][off];
                        rd_valid     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; validity gates every use.
    always_ff @(posedge clock) begin
        if (req && hit && wr_cpu) data_q[hit_way][idx][off] <= data_cpu_in;
        if ((state_q == REFILL) && ready_mem) begin
            data_q[victim_q][idx][cnt_q] <= data_mem_in;
            if (last_word) tag_q[victim_q][idx] <= tag_in;
        end
        if ((state_q == RESPOND) && pend_wr_q) data_q[victim_q][idx][off] <= wdata_q;
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (req) begin
            if (hit && (hit_count != 16'hFFFF))   hit_count  <= hit_count + 16'd1;
            if (!hit && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_nwsa.sv
// Bench for cache_nwsa at default parameters. The reference keeps a flat
// CPU-visible memory image plus per-set residency with use timestamps.
module tb_cache_nwsa;
    localparam int ADDR_W = 16, DATA_W = 8, WAYS = 2, SETS = 16, WORDS = 4;

    logic              clock, reset_n;
    logic [ADDR_W-1:0] addr_cpu;
    logic              rd_cpu, wr_cpu;
    logic [DATA_W-1:0] data_cpu_in, data_cpu_out;
    logic              rd_valid, stall_cpu;
    logic [ADDR_W-1:0] addr_mem;
    logic              rd_mem, wr_mem;
    logic [DATA_W-1:0] data_mem_in, data_mem_out;
    logic              ready_mem;
    logic [15:0]       hit_count, miss_count;

    cache_nwsa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
        .clock(clock), .reset_n(reset_n),
        .addr_cpu(addr_cpu), .rd_cpu(rd_cpu), .wr_cpu(wr_cpu),
        .data_cpu_in(data_cpu_in), .data_cpu_out(data_cpu_out),
        .rd_valid(rd_valid), .stall_cpu(stall_cpu),
        .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .data_mem_in(data_mem_in), .data_mem_out(data_mem_out),
        .ready_mem(ready_mem), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
    } beat_t;

    logic [7:0] mainmem [65536];
    logic [7:0] golden  [65536];
    logic [9:0] m_tag   [WAYS][SETS];
    bit         m_valid [WAYS][SETS];
    bit         m_dirty [WAYS][SETS];
    int         m_stamp [WAYS][SETS];
    int         stamp_ctr;
    int         exp_hits, exp_misses;
    int         n_tests, n_fail;

    task automatic model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
                m_stamp[w][s] = 0;
            end
        for (int i = 0; i < 65536; i++) golden[i] = mainmem[i];
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic idle_inputs();
        rd_cpu = 0; wr_cpu = 0; addr_cpu = '0; data_cpu_in = '0;
        ready_mem = 0; data_mem_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset_n = 1;
        model_clear();
    endtask

    // op: 0 read, 1 write, 2 read+write (acts as write)
    // rmode: 0 ready always, 1 pattern 1,0,0, 2 random
    task automatic access(input logic [15:0] a, input int op, input logic [7:0] wd,
                          input int rmode, input int abort_after,
                          output logic [7:0] rdata, output bit aborted);
        bit is_wr, hit, found, done, r;
        int hw, vw, acc_rd, oldest;
        logic [9:0] tg;
        logic [3:0] ix;
        beat_t b;
        beat_t q[$];
        is_wr = (op != 0); tg = a[15:6]; ix = a[5:2];
        hit = 0; hw = 0; vw = 0; aborted = 0; rdata = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][ix] && m_tag[w][ix] == tg) begin hit = 1; hw = w; end
        @(negedge clock);
        addr_cpu = a; rd_cpu = (op != 1); wr_cpu = (op != 0); data_cpu_in = wd;
        @(negedge clock);
        if (hit) begin
            n_tests++;
            if (stall_cpu !== 1'b0) begin n_fail++; $display("FAIL hit_stall addr=%h got=%b exp=0", a, stall_cpu); end
            n_tests++;
            if (rd_valid !== !is_wr) begin n_fail++; $display("FAIL hit_rd_valid addr=%h got=%b exp=%b", a, rd_valid, !is_wr); end
            if (!is_wr) begin
                n_tests++;
                if (data_cpu_out !== golden[a]) begin n_fail++; $display("FAIL hit_data addr=%h got=%h exp=%h", a, data_cpu_out, golden[a]); end
                rdata = data_cpu_out;
            end else begin
                golden[a] = wd;
                m_dirty[hw][ix] = 1;
            end
            m_stamp[hw][ix] = ++stamp_ctr;
            exp_hits++;
            rd_cpu = 0; wr_cpu = 0;
            return;
        end
        n_tests++;
        if (stall_cpu !== 1'b1) begin n_fail++; $display("FAIL miss_stall addr=%h got=%b exp=1", a, stall_cpu); end
        exp_misses++;
        found = 0;
        for (int w = 0; w < WAYS; w++)
            if (!found && !m_valid[w][ix]) begin vw = w; found = 1; end
        if (!found) begin
            oldest = 32'h7FFFFFFF;
            for (int w = 0; w < WAYS; w++)
                if (m_stamp[w][ix] < oldest) begin oldest = m_stamp[w][ix]; vw = w; end
        end
        if (m_valid[vw][ix] && m_dirty[vw][ix])
            for (int k = 0; k < WORDS; k++) begin
                b.wr = 1'b1; b.addr = {m_tag[vw][ix], ix, 2'(k)}; q.push_back(b);
            end
        for (int k = 0; k < WORDS; k++) begin
            b.wr = 1'b0; b.addr = {tg, ix, 2'(k)}; q.push_back(b);
        end
        m_tag[vw][ix] = tg; m_valid[vw][ix] = 1; m_dirty[vw][ix] = is_wr;
        m_stamp[vw][ix] = ++stamp_ctr;
        if (is_wr) golden[a] = wd;
        acc_rd = 0; done = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (abort_after >= 0 && acc_rd == abort_after) begin
                aborted = 1;
                rd_cpu = 0; wr_cpu = 0; ready_mem = 0;
                return;
            end
            if (!stall_cpu) begin
                done = 1;
            end else if (rd_mem || wr_mem) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL extra_beat got addr=%h rd=%b wr=%b exp=none", addr_mem, rd_mem, wr_mem);
                end else if (wr_mem !== q[0].wr || rd_mem === wr_mem || addr_mem !== q[0].addr) begin
                    n_fail++; $display("FAIL burst_beat got addr=%h rd=%b wr=%b exp addr=%h wr=%b", addr_mem, rd_mem, wr_mem, q[0].addr, q[0].wr);
                end
                if (wr_mem === 1'b1) begin
                    n_tests++;
                    if (data_mem_out !== golden[addr_mem]) begin
                        n_fail++; $display("FAIL wb_data addr=%h got=%h exp=%h", addr_mem, data_mem_out, golden[addr_mem]);
                    end
                end
                case (rmode)
                    0:       r = 1;
                    1:       r = (cyc % 3 == 0);
                    default: r = ($urandom_range(0, 1) == 1);
                endcase
                ready_mem   = r;
                data_mem_in = mainmem[addr_mem];
                if (r) begin
                    if (wr_mem) mainmem[addr_mem] = data_mem_out;
                    else        acc_rd++;
                    if (q.size() > 0) void'(q.pop_front());
                end
            end else begin
                n_tests++;
                if (q.size() != 0) begin n_fail++; $display("FAIL respond_early got beats_left=%0d exp=0", q.size()); end
                ready_mem = 0;
            end
            if (!done) @(negedge clock);
        end
        ready_mem = 0;
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL miss_timeout addr=%h got stall=%b exp stall=0", a, stall_cpu);
        end else begin
            if (rd_valid !== !is_wr) begin n_fail++; $display("FAIL miss_rd_valid addr=%h got=%b exp=%b", a, rd_valid, !is_wr); end
            if (!is_wr) begin
                n_tests++;
                if (data_cpu_out !== golden[a]) begin n_fail++; $display("FAIL miss_data addr=%h got=%h exp=%h", a, data_cpu_out, golden[a]); end
                rdata = data_cpu_out;
            end
        end
        rd_cpu = 0; wr_cpu = 0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 0;
        idle_inputs();
        #1;
        n_tests++;
        if ({rd_valid, stall_cpu, rd_mem, wr_mem} !== 4'b0 || data_cpu_out !== 8'h0 ||
            addr_mem !== 16'h0 || data_mem_out !== 8'h0) begin
            n_fail++; $display("FAIL reset_outputs got rv=%b st=%b rd=%b wr=%b do=%h am=%h dm=%h exp all 0",
                               rd_valid, stall_cpu, rd_mem, wr_mem, data_cpu_out, addr_mem, data_mem_out);
        end
        n_tests++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            n_fail++; $display("FAIL reset_counts got hit=%0d miss=%0d exp 0", hit_count, miss_count);
        end
        repeat (2) @(negedge clock);
        reset_n = 1;
        model_clear();
        @(negedge clock);
        n_tests++;
        if (stall_cpu !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got st=%b rv=%b exp 0", stall_cpu, rd_valid);
        end
    endtask

    task automatic test_directed();
        logic [7:0] rd; bit ab;
        logic [7:0] expwb [4];
        expwb[0] = 8'h11; expwb[1] = 8'h22; expwb[2] = 8'h5A; expwb[3] = 8'h44;
        mainmem[16'hC088] = 8'h11; mainmem[16'hC089] = 8'h22;
        mainmem[16'hC08A] = 8'h33; mainmem[16'hC08B] = 8'h44;
        do_reset();
        access(16'hC08B, 0, 8'h00, 0, -1, rd, ab);
        n_tests++;
        if (rd !== 8'h44) begin n_fail++; $display("FAIL s1_read got=%h exp=44", rd); end
        access(16'hC089, 0, 8'h00, 0, -1, rd, ab);
        n_tests++;
        if (rd !== 8'h22) begin n_fail++; $display("FAIL s2_hit got=%h exp=22", rd); end
        access(16'hC08A, 1, 8'h5A, 0, -1, rd, ab);
        access(16'h008B, 0, 8'h00, 0, -1, rd, ab);
        access(16'h408B, 0, 8'h00, 0, -1, rd, ab);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (mainmem[16'hC088 + k] !== expwb[k]) begin
                n_fail++; $display("FAIL s3_wb_word%0d got=%h exp=%h", k, mainmem[16'hC088 + k], expwb[k]);
            end
        end
        n_tests++;
`ifdef CACHE_STATS_EN
        if (hit_count !== 16'd2 || miss_count !== 16'd3) begin
            n_fail++; $display("FAIL s6_stats got hit=%0d miss=%0d exp hit=2 miss=3", hit_count, miss_count);
        end
`else
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            n_fail++; $display("FAIL s6_stats_off got hit=%0d miss=%0d exp 0", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_ready_toggle();
        logic [7:0] rd; bit ab;
        do_reset();
        access(16'h1234, 0, 8'h00, 1, -1, rd, ab);
        access(16'h1236, 1, 8'hA5, 1, -1, rd, ab);
        access(16'h5234, 0, 8'h00, 1, -1, rd, ab);
        access(16'h9236, 0, 8'h00, 1, -1, rd, ab);
        access(16'h1236, 0, 8'h00, 1, -1, rd, ab);
        n_tests++;
        if (rd !== 8'hA5) begin n_fail++; $display("FAIL toggle_final got=%h exp=a5", rd); end
    endtask

    task automatic test_reset_midburst();
        logic [7:0] rd; bit ab;
        do_reset();
        access(16'h408A, 1, 8'h77, 0, -1, rd, ab);
        access(16'h808B, 0, 8'h00, 0, -1, rd, ab);
        access(16'hC08B, 0, 8'h00, 2, 2, rd, ab);
        n_tests++;
        if (!ab) begin n_fail++; $display("FAIL abort_reached got=0 exp=1"); end
        reset_n = 0;
        #1;
        n_tests++;
        if (stall_cpu !== 1'b0 || rd_mem !== 1'b0 || wr_mem !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs got st=%b rd=%b wr=%b exp 0", stall_cpu, rd_mem, wr_mem);
        end
        repeat (2) @(negedge clock);
        reset_n = 1;
        model_clear();
        access(16'hC08B, 0, 8'h00, 0, -1, rd, ab);
        n_tests++;
        if (rd !== mainmem[16'hC08B]) begin n_fail++; $display("FAIL after_abort_read got=%h exp=%h", rd, mainmem[16'hC08B]); end
    endtask

    task automatic test_random();
        logic [7:0] rd; bit ab;
        logic [15:0] a;
        do_reset();
        for (int n = 0; n < 250; n++) begin
            a = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 2) << 2) | $urandom_range(0, 3));
            access(a, int'($urandom_range(0, 2)), 8'($urandom), 2, -1, rd, ab);
        end
        n_tests++;
`ifdef CACHE_STATS_EN
        if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
            n_fail++; $display("FAIL random_stats got hit=%0d miss=%0d exp hit=%0d miss=%0d", hit_count, miss_count, exp_hits, exp_misses);
        end
`else
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            n_fail++; $display("FAIL random_stats_off got hit=%0d miss=%0d exp 0", hit_count, miss_count);
        end
`endif
    endtask

    initial begin
        n_tests = 0; n_fail = 0; stamp_ctr = 0;
        reset_n = 1;
        idle_inputs();
        for (int i = 0; i < 65536; i++) mainmem[i] = 8'($urandom);
        model_clear();
        test_reset();
        test_directed();
        test_ready_toggle();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
